// File: rtl/mux4_arb_if.sv
// Bus bundle for the 4-requester arbiter: request/data inputs, one-hot grant,
// and the valid/ready output word. The arbiter takes the slave view; the
// requesters and the consumer together take the master view.
interface mux4_arb_if #(
  parameter int WIDTH = 12
);
  logic [3:0]       req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [3:0]       gnt;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_ready;

  // Requesters and consumer side
  modport master (
    output req, d0, d1, d2, d3, out_ready,
    input  gnt, out_valid, out_data, out_src
  );

  // Arbiter side
  modport slave (
    input  req, d0, d1, d2, d3, out_ready,
    output gnt, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux4_arb.sv
// Four-way round-robin arbiter sharing a single 4:1 select path into a
// one-entry output register. A word is granted whenever the register is empty
// or is being drained in the same cycle, so a steady stream runs without
// bubbles while the consumer is ready.
module mux4_arb #(
  parameter int WIDTH = 12
) (
  input  logic     clk,
  input  logic     reset,
  mux4_arb_if.slave bus
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [1:0]       r_ptr;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_src;

  logic             w_found;
  logic [1:0]       w_winner;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_data;
  logic [3:0]       w_gnt;

  // Round-robin search starting at ptr; returns {found, index}. Walking the
  // offsets downwards lets the lowest offset overwrite the result last.
  function automatic logic [2:0] rr_pick(input logic [3:0] req_v, input logic [1:0] ptr_v);
    logic [2:0] res;
    logic [1:0] idx;
    res = {1'b0, ptr_v};
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_v + 2'(k);
      if (req_v[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Winner selection and accept decision from current state and inputs
  always_comb begin
    {w_found, w_winner} = rr_pick(bus.req, r_ptr);
    w_accept = w_found && ((r_state == ST_EMPTY) || bus.out_ready);
  end

  // Shared 4:1 data select driven by the current winner
  always_comb begin
    w_sel_data = bus.d0;
    case (w_winner)
      2'd0:    w_sel_data = bus.d0;
      2'd1:    w_sel_data = bus.d1;
      2'd2:    w_sel_data = bus.d2;
      2'd3:    w_sel_data = bus.d3;
      default: w_sel_data = bus.d0;
    endcase
  end

  // One-hot grant, forced low during reset so no requester drops a word
  always_comb begin
    w_gnt = 4'b0000;
    if (w_accept && !reset) begin
      w_gnt = 4'b0001 << w_winner;
    end else begin
      w_gnt = 4'b0000;
    end
  end

  // Output register occupancy: load on accept, drain on pop, else hold
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end else if (bus.out_ready) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Captured word, its source and the round-robin pointer; all move only on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_src  <= 2'd0;
      r_ptr  <= 2'd0;
    end else if (w_accept) begin
      r_data <= w_sel_data;
      r_src  <= w_winner;
      r_ptr  <= w_winner + 2'd1;
    end else begin
      r_data <= r_data;
      r_src  <= r_src;
      r_ptr  <= r_ptr;
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.out_valid = (r_state == ST_FULL);
  assign bus.out_data  = r_data;
  assign bus.out_src   = r_src;

endmodule

// File: tb/tb_mux4_arb.sv
// Bench for mux4_arb: directed vectors with hand-computed results, then a
// random request/backpressure run checked against a small reference model
// and an in-order scoreboard.
module tb_mux4_arb;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  mux4_arb_if #(.WIDTH(12)) bus ();

  mux4_arb #(.WIDTH(12)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply req/out_ready, check the combinational grant mid-cycle, then take the edge
  task automatic drive_cycle(input logic [3:0] r, input logic rdy, input logic [3:0] eg, input string tag);
    bus.req       = r;
    bus.out_ready = rdy;
    @(negedge clk);
    check({tag, ".gnt"}, 32'(bus.gnt), 32'(eg));
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [11:0] dat, input logic [1:0] s);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".data"},  32'(bus.out_data),  32'(dat));
    check({tag, ".src"},   32'(bus.out_src),   32'(s));
  endtask

  task automatic set_data(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c, input logic [11:0] e);
    bus.d0 = a;
    bus.d1 = b;
    bus.d2 = c;
    bus.d3 = e;
  endtask

  initial begin
    logic [3:0]  eg;
    logic [11:0] pdata [4];
    bit          pend [4];
    logic [13:0] q [$];
    bit          mvalid;
    int          mptr;
    bit          macc;
    int          w;
    bit          rdy;
    logic [3:0]  rq;

    // ---- reset, with a live request that must not be granted ----
    reset = 1'b1;
    bus.req = 4'b0100;
    bus.out_ready = 1'b1;
    set_data(12'h000, 12'h000, 12'hABC, 12'h000);
    @(posedge clk);
    #1;
    drive_cycle(4'b0100, 1'b1, 4'b0000, "rst");
    check_out("rst", 1'b0, 12'h000, 2'd0);
    reset = 1'b0;

    // ---- single request from idle ----
    drive_cycle(4'b0100, 1'b1, 4'b0100, "single");
    check_out("single", 1'b1, 12'hABC, 2'd2);

    // ---- pointer is now 3: all-request stream starts at 3, then rotates 0..3,0 ----
    set_data(12'h100, 12'h101, 12'h102, 12'h103);
    drive_cycle(4'b1111, 1'b1, 4'b1000, "ptr3");
    check_out("ptr3", 1'b1, 12'h103, 2'd3);
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      drive_cycle(4'b1111, 1'b1, eg, $sformatf("rr%0d", k));
      check_out($sformatf("rr%0d", k), 1'b1, 12'(12'h100 + (k % 4)), 2'(k % 4));
    end

    // ---- backpressure: hold word from source 1 for five cycles ----
    drive_cycle(4'b0010, 1'b1, 4'b0010, "fill1");
    check_out("fill1", 1'b1, 12'h101, 2'd1);
    for (int k = 0; k < 5; k++) begin
      drive_cycle(4'b0001, 1'b0, 4'b0000, $sformatf("stall%0d", k));
      check_out($sformatf("stall%0d", k), 1'b1, 12'h101, 2'd1);
    end
    drive_cycle(4'b0001, 1'b1, 4'b0001, "release");
    check_out("release", 1'b1, 12'h100, 2'd0);

    // ---- drain with no requests: data retained, valid drops ----
    drive_cycle(4'b0000, 1'b1, 4'b0000, "drain");
    check_out("drain", 1'b0, 12'h100, 2'd0);
    drive_cycle(4'b0000, 1'b0, 4'b0000, "idle");
    check_out("idle", 1'b0, 12'h100, 2'd0);

    // ---- mid-operation reset with pointer at 2 and pending requests ----
    drive_cycle(4'b0010, 1'b1, 4'b0010, "pre_rst");
    check_out("pre_rst", 1'b1, 12'h101, 2'd1);
    reset = 1'b1;
    drive_cycle(4'b1010, 1'b0, 4'b0000, "mid_rst");
    check_out("mid_rst", 1'b0, 12'h000, 2'd0);
    reset = 1'b0;
    drive_cycle(4'b1010, 1'b1, 4'b0010, "post_rst");
    check_out("post_rst", 1'b1, 12'h101, 2'd1);

    // ---- accept into an empty register while the consumer is not ready ----
    drive_cycle(4'b0000, 1'b1, 4'b0000, "empty2");
    check_out("empty2", 1'b0, 12'h101, 2'd1);
    drive_cycle(4'b1000, 1'b0, 4'b1000, "empty_acc");
    check_out("empty_acc", 1'b1, 12'h103, 2'd3);

    // ---- random traffic against reference model and scoreboard ----
    reset = 1'b1;
    drive_cycle(4'b0000, 1'b0, 4'b0000, "rnd_rst");
    reset = 1'b0;
    mvalid = 1'b0;
    mptr   = 0;
    for (int i = 0; i < 4; i++) begin
      pend[i]  = 1'b0;
      pdata[i] = 12'h000;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]  = 1'b1;
          pdata[i] = 12'($urandom_range(0, 4095));
        end
      end
      rq  = {pend[3], pend[2], pend[1], pend[0]};
      rdy = ($urandom_range(0, 2) != 0);
      bus.req       = rq;
      bus.out_ready = rdy;
      set_data(pdata[0], pdata[1], pdata[2], pdata[3]);
      @(negedge clk);

      w = -1;
      for (int k = 0; k < 4; k++) begin
        if (w < 0 && pend[(mptr + k) % 4]) w = (mptr + k) % 4;
      end
      macc = (w >= 0) && (!mvalid || rdy);
      eg = macc ? (4'b0001 << w) : 4'b0000;
      check("rnd.gnt", 32'(bus.gnt), 32'(eg));
      check("rnd.valid", 32'(bus.out_valid), 32'(mvalid));
      if (mvalid && q.size() > 0) begin
        check("rnd.word", 32'({bus.out_src, bus.out_data}), 32'(q[0]));
      end

      if (mvalid && rdy && q.size() > 0) void'(q.pop_front());
      if (macc) begin
        q.push_back({2'(w), pdata[w]});
        pend[w] = 1'b0;
        mptr = (w + 1) % 4;
      end
      mvalid = macc || (mvalid && !rdy);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux4_arb.md
MUX4_ARB -- requirements
Module: mux4_arb

Interface
REQ-001 Parameter: WIDTH, default 12, data width of every requester and of the output.
REQ-002 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 Port: reset, input, 1, synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 Port: req, input, 4, req[i] high = requester i presents valid data on d<i>.
REQ-005 Port: d0, d1, d2, d3, input, WIDTH each, requester data.
REQ-006 Port: gnt, output, 4, one-hot or zero; gnt[i] high = d<i> is captured at this rising edge.
REQ-007 Port: out_valid, output, 1, the output register holds an unconsumed word.
REQ-008 Port: out_data, output, WIDTH, the captured word.
REQ-009 Port: out_src, output, 2, the index of the requester whose word is in out_data.
REQ-010 Port: out_ready, input, 1, the consumer accepts out_data in the cycle when out_valid && out_ready.

Function
REQ-011 The block SHALL share one 4:1 WIDTH-bit select path among four requesters, feeding a single-entry output register (states EMPTY when out_valid=0 and FULL when out_valid=1).
REQ-012 accept = req != 0 && (out_valid == 0 || out_ready == 1); it is combinational from current state and inputs.
REQ-013 The winner SHALL be the first index i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4), where ptr is a 2-bit round-robin pointer.
REQ-014 gnt[winner] SHALL be 1 combinationally in the cycle accept=1; gnt SHALL be 4'b0000 whenever accept=0 or reset=1.
REQ-015 On an edge with accept=1: out_data <= d<winner>, out_src <= winner, out_valid <= 1, ptr <= (winner+1) mod 4.
REQ-016 On an edge with accept=0 and out_valid && out_ready: out_valid <= 0; out_data and out_src hold their values.
REQ-017 On an edge with accept=0 and (out_valid == 0 or out_ready == 0): all state holds; ptr changes only on accept.
REQ-018 Latency: data granted at edge N SHALL appear on out_data/out_valid after edge N; throughput is one word per cycle while out_ready=1.
REQ-019 Simultaneous pop and accept (FULL, out_ready=1, req!=0): the old word is consumed and the new word is loaded on the same edge; no bubble.
REQ-020 Backpressure (FULL, out_ready=0): gnt=0, and out_data, out_src and ptr SHALL be stable until out_ready rises.
REQ-021 A requester SHALL hold req[i] and d<i> until it sees gnt[i]; the block SHALL not lose or duplicate words.
REQ-022 Fairness: with all four req high continuously and out_ready=1, grants SHALL rotate so that no requester waits more than 3 grants.
REQ-023 out_src and gnt SHALL be consistent: the word captured under gnt[i] SHALL carry out_src=i.

Reset
REQ-024 While reset=1 at an edge: out_valid <= 0, out_data <= 0, out_src <= 0, ptr <= 0; gnt=0 during the reset cycle.
REQ-025 Reset asserted mid-operation (FULL, pending reqs) SHALL discard the held word; the first accept after reset searches from index 0.

Verification
REQ-026 Reset, then req=4'b0100, d2=12'hABC, out_ready=1 -> gnt=4'b0100 that cycle; next cycle out_valid=1, out_data=12'hABC, out_src=2; ptr=3.
REQ-027 req=4'b1111 held, out_ready=1, d<i>=12'h100+i, starting from ptr=0 -> out_src sequence 0,1,2,3,0 on consecutive cycles with no gaps.
REQ-028 FULL with out_src=1, out_ready=0 for 5 cycles, req=4'b0001 -> gnt=0 throughout and out_data unchanged; out_ready=1 -> gnt=4'b0001 in the same cycle and out_src=0 next cycle.
REQ-029 FULL, out_ready=1, req=0 -> out_valid=0 next cycle; out_data retains its last value.
REQ-030 FULL with ptr=2, req=4'b1010, assert reset for one cycle -> out_valid=0 and ptr=0; next accept grants index 1 (gnt=4'b0010).
REQ-031 Random req/out_ready for 10k cycles with a scoreboard -> every granted word is delivered exactly once, in grant order, with the correct out_src.
